cpu_debug_jtag_host: RTL and testbench

CPU_DEBUG_JTAG_HOST -- requirements
Module: cpu_debug_jtag_host

---
 rtl/cpu_debug_jtag_host_pkg.sv | 18 +
 rtl/cpu_debug_jtag_host_if.sv | 28 ++
 rtl/cpu_debug_jtag_tick_gen.sv | 30 +++
 rtl/cpu_debug_jtag_host.sv | 135 +++++++++++++
 tb/tb_cpu_debug_jtag_host.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_debug_jtag_host_pkg.sv
// Shared types and default geometry for the CPU debug JTAG host.
package cpu_debug_jtag_host_pkg;

  localparam int unsigned DEF_DR_WIDTH = 38;
  localparam int unsigned DEF_IR_WIDTH = 2;
  // Wide enough for the largest legal TCK_DIV (255).
  localparam int unsigned TICK_CNT_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UIR,
    ST_CDR,
    ST_SDR,
    ST_UDR,
    ST_RSP
  } jtag_state_e;

endpackage

// File: rtl/cpu_debug_jtag_host_if.sv
// Command/response handshake bundle between a requester and the JTAG host.
interface cpu_debug_jtag_host_if
  import cpu_debug_jtag_host_pkg::*;
#(
  parameter int unsigned DR_WIDTH = DEF_DR_WIDTH,
  parameter int unsigned IR_WIDTH = DEF_IR_WIDTH
);

  logic                cmd_valid;
  logic                cmd_ready;
  logic [IR_WIDTH-1:0] cmd_ir;
  logic [DR_WIDTH-1:0] cmd_dr;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DR_WIDTH-1:0] rsp_data;
  logic [IR_WIDTH-1:0] rsp_ir_out;

  modport master (
    output cmd_valid, cmd_ir, cmd_dr, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_ir_out
  );

  modport slave (
    input  cmd_valid, cmd_ir, cmd_dr, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_ir_out
  );

endinterface

// File: rtl/cpu_debug_jtag_tick_gen.sv
// Virtual TCK divider: one-cycle tick on the last clk of every TCK_DIV window.
module cpu_debug_jtag_tick_gen
  import cpu_debug_jtag_host_pkg::*;
#(
  parameter int unsigned TCK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam logic [TICK_CNT_W-1:0] LAST = TICK_CNT_W'(TCK_DIV - 1);

  logic [TICK_CNT_W-1:0] cnt;

  // Count through one window and wrap; held at zero while cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + TICK_CNT_W'(1);
    end
  end

  assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/cpu_debug_jtag_host.sv
// Host-side virtual JTAG sequencer: loads an instruction, shifts one data
// register LSB first through tdi/tdo and returns the captured bits.
module cpu_debug_jtag_host
  import cpu_debug_jtag_host_pkg::*;
#(
  parameter int unsigned DR_WIDTH = DEF_DR_WIDTH,
  parameter int unsigned IR_WIDTH = DEF_IR_WIDTH,
  parameter int unsigned TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  cpu_debug_jtag_host_if.slave host,
  output logic [IR_WIDTH-1:0] ir_in,
  input  logic [IR_WIDTH-1:0] ir_out,
  output logic                tck,
  output logic                tdi,
  input  logic                tdo,
  output logic                vs_uir,
  output logic                vs_cdr,
  output logic                vs_sdr,
  output logic                vs_udr,
  output logic                jtag_state_rti
);

  localparam int unsigned BIT_CNT_W = $clog2(DR_WIDTH + 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DR_WIDTH - 1);

  jtag_state_e state;
  jtag_state_e state_nxt;

  logic                 tick;
  logic                 busy;
  logic                 accept;
  logic [IR_WIDTH-1:0]  ir_q;
  logic [DR_WIDTH-1:0]  dr_q;
  logic [DR_WIDTH-1:0]  rsp_data_q;
  logic [IR_WIDTH-1:0]  rsp_ir_q;
  logic [BIT_CNT_W-1:0] bit_cnt;

  assign busy   = (state == ST_UIR) || (state == ST_CDR) ||
                  (state == ST_SDR) || (state == ST_UDR);
  assign accept = host.cmd_valid && (state == ST_IDLE);

  // Divider is held clear outside the scan states, so the first window
  // begins on the cycle after acceptance.
  cpu_debug_jtag_tick_gen #(
    .TCK_DIV(TCK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(reset_n),
    .clr  (!busy),
    .tick (tick)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    state_nxt      = state;
    host.cmd_ready = 1'b0;
    host.rsp_valid = 1'b0;
    jtag_state_rti = 1'b0;
    vs_uir         = 1'b0;
    vs_cdr         = 1'b0;
    vs_sdr         = 1'b0;
    vs_udr         = 1'b0;
    unique case (state)
      ST_IDLE: begin
        host.cmd_ready = 1'b1;
        jtag_state_rti = 1'b1;
        if (host.cmd_valid) state_nxt = ST_UIR;
      end
      ST_UIR: begin
        vs_uir = 1'b1;
        if (tick) state_nxt = ST_CDR;
      end
      ST_CDR: begin
        vs_cdr = 1'b1;
        if (tick) state_nxt = ST_SDR;
      end
      ST_SDR: begin
        vs_sdr = 1'b1;
        if (tick && bit_cnt == LAST_BIT) state_nxt = ST_UDR;
      end
      ST_UDR: begin
        vs_udr = 1'b1;
        if (tick) state_nxt = ST_RSP;
      end
      ST_RSP: begin
        host.rsp_valid = 1'b1;
        if (host.rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign tck             = tick;
  assign tdi             = vs_sdr && dr_q[0];
  assign ir_in           = busy ? ir_q : '0;
  assign host.rsp_data   = rsp_data_q;
  assign host.rsp_ir_out = rsp_ir_q;

  // Command registers, tdo capture and bit counter; dr_q shifts right so
  // tdi always presents the current bit from position 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_q       <= '0;
      dr_q       <= '0;
      rsp_data_q <= '0;
      rsp_ir_q   <= '0;
      bit_cnt    <= '0;
    end else begin
      if (accept) begin
        ir_q <= host.cmd_ir;
        dr_q <= host.cmd_dr;
      end
      if (tick && state == ST_UIR) begin
        rsp_ir_q <= ir_out;
      end
      if (tick && state == ST_SDR) begin
        dr_q       <= dr_q >> 1;
        rsp_data_q <= {tdo, rsp_data_q[DR_WIDTH-1:1]};
        bit_cnt    <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BIT_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cpu_debug_jtag_host.sv
// Scoreboard bench for cpu_debug_jtag_host: a default-divider instance and a
// TCK_DIV=5 instance share the stimulus; the monitor follows the selected one.
module tb_cpu_debug_jtag_host;
  import cpu_debug_jtag_host_pkg::*;

  localparam int unsigned DW = 38;
  localparam int unsigned IW = 2;

  typedef struct {
    logic [DW-1:0] data;
    logic [IW-1:0] irout;
    logic [IW-1:0] irin;
    int            lat;
    int            div;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Stimulus variables
  logic          cmd_valid;
  logic [IW-1:0] cmd_ir;
  logic [DW-1:0] cmd_dr;
  logic          rsp_ready;
  logic          tdo_one;
  logic [IW-1:0] ir_out_v;
  logic          use5;

  cpu_debug_jtag_host_if #(.DR_WIDTH(DW), .IR_WIDTH(IW)) ifa ();
  cpu_debug_jtag_host_if #(.DR_WIDTH(DW), .IR_WIDTH(IW)) ifb ();

  assign ifa.cmd_valid = cmd_valid & ~use5;
  assign ifb.cmd_valid = cmd_valid & use5;
  assign ifa.cmd_ir    = cmd_ir;
  assign ifb.cmd_ir    = cmd_ir;
  assign ifa.cmd_dr    = cmd_dr;
  assign ifb.cmd_dr    = cmd_dr;
  assign ifa.rsp_ready = rsp_ready;
  assign ifb.rsp_ready = rsp_ready;

  logic [IW-1:0] ir_in_a, ir_in_b;
  logic tck_a, tck_b, tdi_a, tdi_b, tdo_a, tdo_b;
  logic uir_a, cdr_a, sdr_a, udr_a, rti_a;
  logic uir_b, cdr_b, sdr_b, udr_b, rti_b;

  assign tdo_a = tdo_one ? 1'b1 : tdi_a;
  assign tdo_b = tdo_one ? 1'b1 : tdi_b;

  cpu_debug_jtag_host dut (
    .clk(clk), .reset_n(rst_n), .host(ifa.slave),
    .ir_in(ir_in_a), .ir_out(ir_out_v), .tck(tck_a), .tdi(tdi_a), .tdo(tdo_a),
    .vs_uir(uir_a), .vs_cdr(cdr_a), .vs_sdr(sdr_a), .vs_udr(udr_a),
    .jtag_state_rti(rti_a)
  );

  cpu_debug_jtag_host #(.TCK_DIV(5)) dut5 (
    .clk(clk), .reset_n(rst_n), .host(ifb.slave),
    .ir_in(ir_in_b), .ir_out(ir_out_v), .tck(tck_b), .tdi(tdi_b), .tdo(tdo_b),
    .vs_uir(uir_b), .vs_cdr(cdr_b), .vs_sdr(sdr_b), .vs_udr(udr_b),
    .jtag_state_rti(rti_b)
  );

  // Selected-DUT view: vs = {uir, cdr, sdr, udr}
  logic          s_cmd_ready, s_rsp_valid, s_tck, s_tdi, s_rti;
  logic [DW-1:0] s_rsp_data;
  logic [IW-1:0] s_rsp_ir_out, s_ir_in;
  logic [3:0]    s_vs;

  assign s_cmd_ready  = use5 ? ifb.cmd_ready  : ifa.cmd_ready;
  assign s_rsp_valid  = use5 ? ifb.rsp_valid  : ifa.rsp_valid;
  assign s_rsp_data   = use5 ? ifb.rsp_data   : ifa.rsp_data;
  assign s_rsp_ir_out = use5 ? ifb.rsp_ir_out : ifa.rsp_ir_out;
  assign s_ir_in      = use5 ? ir_in_b : ir_in_a;
  assign s_tck        = use5 ? tck_b : tck_a;
  assign s_tdi        = use5 ? tdi_b : tdi_a;
  assign s_rti        = use5 ? rti_b : rti_a;
  assign s_vs         = use5 ? {uir_b, cdr_b, sdr_b, udr_b} : {uir_a, cdr_a, sdr_a, udr_a};

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: event did not occur as required", name);
  endtask

  always @(posedge clk) cyc++;

  // Monitor / scoreboard
  int            accept_edge = 0, last_tck = -1, lat = -1;
  int            n_uir = 0, n_cdr = 0, n_sdr = 0, n_udr = 0, gap_bad = 0, viol = 0;
  logic          prev_rv = 1'b0;
  logic [DW-1:0] held_data;
  logic [IW-1:0] held_ir, exp_irin;
  exp_t          e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_rv = 1'b0;
    end else begin
      if (cmd_valid && s_cmd_ready) begin
        accept_edge = cyc + 1;
        n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0;
        gap_bad = 0; last_tck = -1; lat = -1;
      end
      if (s_tck) begin
        if (last_tck >= 0 && exp_q.size() > 0 && (cyc - last_tck) != exp_q[0].div) gap_bad++;
        last_tck = cyc;
        if (s_vs[3]) n_uir++;
        if (s_vs[2]) n_cdr++;
        if (s_vs[1]) n_sdr++;
        if (s_vs[0]) n_udr++;
        if (s_vs == 4'b0000) viol++;
      end
      if ($countones({s_rti, s_vs, s_rsp_valid}) != 1) viol++;
      if (s_cmd_ready !== s_rti) viol++;
      if (!s_vs[1] && s_tdi) viol++;
      exp_irin = ((|s_vs) && exp_q.size() > 0) ? exp_q[0].irin : '0;
      if (s_ir_in !== exp_irin) viol++;
      if (s_rsp_valid && !prev_rv) begin
        lat = cyc - accept_edge;
        held_data = s_rsp_data;
        held_ir = s_rsp_ir_out;
      end else if (s_rsp_valid && (s_rsp_data !== held_data || s_rsp_ir_out !== held_ir)) begin
        viol++;
      end
      if (s_rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_rsp");
        end else begin
          e = exp_q.pop_front();
          chk("rsp_data", 64'(s_rsp_data), 64'(e.data));
          chk("rsp_ir_out", 64'(s_rsp_ir_out), 64'(e.irout));
          chk("latency", 64'(lat), 64'(e.lat));
          chk("sdr_ticks", 64'(n_sdr), 64'(DW));
          chk("uir_ticks", 64'(n_uir), 64'd1);
          chk("cdr_ticks", 64'(n_cdr), 64'd1);
          chk("udr_ticks", 64'(n_udr), 64'd1);
          chk("tck_spacing_errs", 64'(gap_bad), 64'd0);
          chk("protocol_errs", 64'(viol), 64'd0);
          viol = 0;
        end
      end
      prev_rv = s_rsp_valid;
    end
  end

  task automatic push_exp(input logic [IW-1:0] ir, input logic [DW-1:0] data,
                          input logic [IW-1:0] irout, input int lt, input int dv);
    exp_t x;
    x.data = data; x.irout = irout; x.irin = ir; x.lat = lt; x.div = dv;
    exp_q.push_back(x);
  endtask

  task automatic issue(input logic [IW-1:0] ir, input logic [DW-1:0] dr,
                       input logic [DW-1:0] data, input logic [IW-1:0] irout,
                       input int lt, input int dv);
    bit ok;
    push_exp(ir, data, irout, lt, dv);
    cmd_ir = ir; cmd_dr = dr; cmd_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (s_cmd_ready) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("accept_timeout");
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      fail_now("rsp_timeout");
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_rsp_valid", 64'(s_rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(s_rsp_data), 64'd0);
    chk("rst_rsp_ir_out", 64'(s_rsp_ir_out), 64'd0);
    chk("rst_ir_in", 64'(s_ir_in), 64'd0);
    chk("rst_tck", 64'(s_tck), 64'd0);
    chk("rst_tdi", 64'(s_tdi), 64'd0);
    chk("rst_vs", 64'(s_vs), 64'd0);
    chk("rst_rti", 64'(s_rti), 64'd1);
    chk("rst_cmd_ready", 64'(s_cmd_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt, d;
    cmd_valid = 1'b0; cmd_ir = '0; cmd_dr = '0; rsp_ready = 1'b1;
    tdo_one = 1'b0; ir_out_v = '0; use5 = 1'b0;
    #12;
    chk_reset_outputs();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Loopback at defaults
    ir_out_v = 2'b01;
    issue(2'b01, 38'h2A_5555_AAAA, 38'h2A_5555_AAAA, 2'b01, 82, 2);
    wait_done();

    // tdo tied high, status 10
    tdo_one = 1'b1; ir_out_v = 2'b10;
    issue(2'b10, 38'h00_0000_0000, 38'h3F_FFFF_FFFF, 2'b10, 82, 2);
    wait_done();
    tdo_one = 1'b0;

    // TCK_DIV=5 instance
    use5 = 1'b1; ir_out_v = 2'b01;
    issue(2'b11, 38'h15_0F0F_3C3C, 38'h15_0F0F_3C3C, 2'b01, 205, 5);
    wait_done();
    use5 = 1'b0;

    // Back-pressured response with a second command waiting
    ir_out_v = 2'b11;
    rsp_ready = 1'b0;
    issue(2'b01, 38'h01_2345_6789, 38'h01_2345_6789, 2'b11, 82, 2);
    d = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (s_rsp_valid) begin d = 1; break; end
    end
    if (d == 0) fail_now("rsp_valid_timeout");
    @(posedge clk); #1;
    push_exp(2'b10, 38'h3E_DCBA_9876, 2'b11, 82, 2);
    cmd_ir = 2'b10; cmd_dr = 38'h3E_DCBA_9876; cmd_valid = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (s_cmd_ready) cnt++;
    end
    chk("busy_accepts", 64'(cnt), 64'd0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    d = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (s_cmd_ready) begin d = k; break; end
    end
    chk("accept_after_rsp_ready", 64'(d), 64'd2);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_done();

    // Reset during SDR bit 17
    issue(2'b01, 38'h20_0001_FFFF, 38'h20_0001_FFFF, 2'b11, 82, 2);
    cnt = 0;
    for (int i = 0; i < 500 && cnt < 17; i++) begin
      @(negedge clk);
      if (s_tck && s_vs[1]) cnt++;
    end
    chk("sdr_ticks_before_abort", 64'(cnt), 64'd17);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    void'(exp_q.pop_back());
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (s_rsp_valid) cnt++;
    end
    chk("rsp_after_abort", 64'(cnt), 64'd0);
    @(posedge clk); #1;
    ir_out_v = 2'b10;
    issue(2'b01, 38'h1F_8000_0001, 38'h1F_8000_0001, 2'b10, 82, 2);
    wait_done();

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
